// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter clocked at the baud rate, one-byte holding register, cts/rts flow control.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data bits and the stop bit(s).
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clock_115200hz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       rts,
  input  logic       cts,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] DATA_MASK = BYTE_W'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,PARITY = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               rts_q, rts_d;
  logic               launch;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // State and datapath registers; reset abandons any partial frame and returns the line to mark.
  always_ff @(posedge clock_115200hz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      rts_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      rts_q        <= rts_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Next-state, next line value and holding-register handshake.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    launch       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_valid_q && cts) launch = 1'b1;
      end
      START: begin
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
          tx_d      = parity_q;
          state_d   = PARITY;
`else
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = STOP;
`endif
        end else begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        state_d   = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_cnt_q == LAST_STOP) begin
          // Back-to-back frames skip IDLE when the next byte is already held.
          if (hold_valid_q && cts) launch = 1'b1;
          else                     state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      tx_d         = 1'b0;
      state_d      = START;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^hold_q;
`endif
    end

    // Accept only while empty, so it can never coincide with a launch.
    if (tx_valid && !hold_valid_q) begin
      hold_d       = tx_data & DATA_MASK;
      hold_valid_d = 1'b1;
    end
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    rts_d  = hold_valid_d | busy_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign rts      = rts_q;
  assign tx_ready = ~hold_valid_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus for uart_tx, checked every cycle against a frame-queue model.
module tb_uart_tx;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 2 + DATA_BITS + STOP_BITS;
`else
  localparam int FL = 1 + DATA_BITS + STOP_BITS;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cts;
  logic       tx_ready, tx, rts, busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
    .clock_115200hz(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .rts(rts),
    .cts(cts),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Whole frame as the line shows it, period k in bit k: start, data LSB first, [parity], stop(s).
  function automatic logic [FL-1:0] frame_vec(input logic [7:0] b);
    logic [FL-1:0] f;
    logic          par;
    f    = '1;
    f[0] = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < int'(DATA_BITS); i++) begin
      f[1+i] = b[i];
      par    = par ^ b[i];
    end
`ifdef UART_TX_PARITY_EN
    f[1+DATA_BITS] = par;
`endif
    return f;
  endfunction

  // Model: queue of line bits still to be shown; a new frame may start only when the queue is empty.
  bit            m_hold_valid = 1'b0;
  logic [7:0]    m_hold = '0;
  bit            m_tx = 1'b1, m_busy = 1'b0, m_rts = 1'b0;
  bit            line[$];
  bit            was_full;
  logic [FL-1:0] fv;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_hold_valid = 1'b0;
      m_tx = 1'b1; m_busy = 1'b0; m_rts = 1'b0;
      line.delete();
    end else begin
      was_full = m_hold_valid;
      if (line.size() == 0 && was_full && cts) begin
        fv = frame_vec(m_hold);
        for (int k = 0; k < FL; k++) line.push_back(fv[k]);
        m_hold_valid = 1'b0;
      end
      if (line.size() != 0) begin
        m_tx = line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
      if (tx_valid && !was_full) begin
        m_hold = tx_data;
        m_hold_valid = 1'b1;
      end
      m_rts = m_hold_valid || m_busy;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx", 32'(tx), 32'(m_tx));
    chk("rts", 32'(rts), 32'(m_rts));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tx_ready", 32'(tx_ready), 32'(!m_hold_valid));
  end

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Sends b into an idle transmitter and samples FL+2 periods starting with the accept period.
  task automatic capture(input logic [7:0] b, output logic [FL+1:0] s_tx, output int nbusy,
                         output logic rts0);
    send(b);
    nbusy = 0;
    rts0  = 1'b0;
    for (int i = 0; i < FL + 2; i++) begin
      @(negedge clk);
      s_tx[i] = tx;
      if (busy) nbusy++;
      if (i == 0) rts0 = rts;
    end
    @(posedge clk);
    #1;
  endtask

  logic [FL+1:0] s_tx;
  int            nbusy;
  logic          rts0;
  logic [7:0]    first_byte;
  logic [31:0]   first_exp, fresh_exp;

  initial begin
`ifdef UART_TX_PARITY_EN
    first_byte = 8'h07; first_exp = 32'h60E; fresh_exp = 32'h502;
`else
    first_byte = 8'hA5; first_exp = 32'h34A; fresh_exp = 32'h302;
`endif
    reset = 1'b1; tx_valid = 1'b0; cts = 1'b1; tx_data = 8'h00;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rts", 32'(rts), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    chk("model_frame", 32'(frame_vec(first_byte)), first_exp);

    // Single frame, literal line pattern
    capture(first_byte, s_tx, nbusy, rts0);
    chk("frame_bits", 32'(s_tx[FL:1]), first_exp);
    chk("idle_before", 32'(s_tx[0]), 32'd1);
    chk("idle_after", 32'(s_tx[FL+1]), 32'd1);
    chk("busy_cycles", 32'(nbusy), 32'(FL));
    chk("rts_at_accept", 32'(rts0), 32'd1);
`ifdef UART_TX_PARITY_EN
    capture(8'h03, s_tx, nbusy, rts0);
    chk("parity_03", 32'(s_tx[FL:1]), 32'h406);
`endif

    // Back-to-back with second byte offered during DATA
    send(8'h00);
    repeat (3) @(posedge clk);
    #1;
    send(8'hFF);
    chk("b2b_ready_low", 32'(tx_ready), 32'd0);
    repeat (FL - 4) @(posedge clk);
    #1;
    chk("b2b_last_stop", 32'(tx), 32'd1);
    chk("b2b_ready_still_low", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_no_gap", 32'(tx), 32'd0);
    chk("b2b_ready_back", 32'(tx_ready), 32'd1);
    repeat (FL + 1) @(posedge clk);
    #1;

    // Held byte waits for cts
    cts = 1'b0;
    send(8'h55);
    repeat (50) @(posedge clk);
    #1;
    chk("cts_wait_tx", 32'(tx), 32'd1);
    chk("cts_wait_rts", 32'(rts), 32'd1);
    chk("cts_wait_ready", 32'(tx_ready), 32'd0);
    chk("cts_wait_busy", 32'(busy), 32'd0);
    cts = 1'b1;
    @(posedge clk);
    #1;
    chk("cts_start", 32'(tx), 32'd0);
    repeat (FL + 1) @(posedge clk);
    #1;

    // cts dropped mid-frame: frame completes, second byte waits
    send(8'h3C);
    @(posedge clk);
    #1;
    send(8'h96);
    repeat (3) @(posedge clk);
    #1;
    cts = 1'b0;
    repeat (FL - 2) @(posedge clk);
    #1;
    chk("ctsdrop_idle_tx", 32'(tx), 32'd1);
    chk("ctsdrop_idle_busy", 32'(busy), 32'd0);
    chk("ctsdrop_rts", 32'(rts), 32'd1);
    cts = 1'b1;
    @(posedge clk);
    #1;
    chk("ctsdrop_resume", 32'(tx), 32'd0);
    repeat (FL + 1) @(posedge clk);
    #1;

    // Reset during data bit 5, then a fresh frame
    send(8'h5A);
    repeat (7) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_rts", 32'(rts), 32'd0);
    chk("midrst_ready", 32'(tx_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    capture(8'h81, s_tx, nbusy, rts0);
    chk("fresh_frame", 32'(s_tx[FL:1]), fresh_exp);

    // Randomized traffic, cts toggling, occasional reset
    for (int c = 0; c < 4000; c++) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cts = ~cts;
      if ($urandom_range(0, 699) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    tx_valid = 1'b0;
    cts = 1'b1;
    repeat (2 * FL + 4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
